// File: rtl/syn_fifo_ptr.sv
`timescale 1ns/1ps
// ============================================================================
// syn_fifo_ptr
// ----------------------------------------------------------------------------
// Single-clock FIFO built on circular read/write pointers with a registered
// read port. Data leaves in strict first-in-first-out order one clock after
// the read request is accepted.
//
// Features:
//   - occupancy output (0..DEPTH) with full / almost-full / empty /
//     almost-empty flags, all decoded from the registered count
//   - simultaneous read and write in the same cycle
//   - sticky overflow / underflow flags, cleared by rst or i_flush
//   - synchronous flush (highest priority, acts as the soft reset)
//   - optional per-entry even parity, enabled by defining the macro
//     SYN_FIFO_PARITY_EN. With the macro undefined the memory is DATA_W wide
//     and o_par_err is held at 0.
//
// Parameters:
//   DATA_W  data width in bits (>= 1)
//   DEPTH   number of entries, power of two, >= 4
//   UPP_TH  almost-full margin : o_alm_full  when DEPTH-UPP_TH <= count < DEPTH
//   LOW_TH  almost-empty margin: o_alm_empty when 0 < count <= LOW_TH
//
// Ports:
//   clk          rising-edge clock for all state
//   rst          asynchronous active-high reset
//   i_flush      synchronous flush; wins over concurrent i_wren / i_rden
//   i_wren       write request
//   i_wrdata     write data
//   o_full       count == DEPTH
//   o_alm_full   almost full (never together with o_full)
//   i_rden       read request
//   o_rddata     read data, valid while o_rd_valid is high, holds otherwise
//   o_rd_valid   one-cycle pulse after an accepted read
//   o_empty      count == 0
//   o_alm_empty  almost empty (never together with o_empty)
//   o_count      current occupancy
//   o_overflow   sticky: write attempted while full
//   o_underflow  sticky: read attempted while empty
//   o_par_err    parity mismatch on the word presented with o_rd_valid
// ============================================================================
module syn_fifo_ptr #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 1024,
    parameter int UPP_TH = 4,
    parameter int LOW_TH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_flush,
    input  logic                          i_wren,
    input  logic [DATA_W-1:0]             i_wrdata,
    output logic                          o_full,
    output logic                          o_alm_full,
    input  logic                          i_rden,
    output logic [DATA_W-1:0]             o_rddata,
    output logic                          o_rd_valid,
    output logic                          o_empty,
    output logic                          o_alm_empty,
    output logic [$clog2(DEPTH):0]        o_count,
    output logic                          o_overflow,
    output logic                          o_underflow,
    output logic                          o_par_err
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

`ifdef SYN_FIFO_PARITY_EN
    // Extra top bit of every entry holds the even parity of the data word.
    localparam int MEM_W  = DATA_W + 1;
`else
    localparam int MEM_W  = DATA_W;
`endif

    // Flag thresholds expressed in the count width so every compare is
    // width-matched.
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_LO_C = CNT_W'(DEPTH - UPP_TH);
    localparam logic [CNT_W-1:0] AEMPTY_C   = CNT_W'(LOW_TH);
    localparam logic [ADDR_W-1:0] PTR_ONE_C = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE_C = CNT_W'(1);

    // Even parity of a data word: the stored bit makes the total count of
    // ones even.
    function automatic logic even_parity(input logic [DATA_W-1:0] data);
        return ^data;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [MEM_W-1:0]  mem_q [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q,    wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q,    rd_ptr_d;
    logic [CNT_W-1:0]  count_q,     count_d;
    logic [DATA_W-1:0] rddata_q,    rddata_d;
    logic              rd_valid_q,  rd_valid_d;
    logic              overflow_q,  overflow_d;
    logic              underflow_q, underflow_d;
    logic              par_err_q,   par_err_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic              full_s;
    logic              empty_s;
    logic              wr_ok_s;
    logic              rd_ok_s;
    logic [MEM_W-1:0]  wr_word_s;
    logic [MEM_W-1:0]  rd_word_s;
    logic              rd_par_bad_s;

    // Status flags decoded from the registered occupancy.
    always_comb begin
        full_s  = (count_q == DEPTH_C);
        empty_s = (count_q == {CNT_W{1'b0}});
    end

    // Accept qualifiers; a flush suppresses both requests.
    always_comb begin
        wr_ok_s = i_wren & ~full_s  & ~i_flush;
        rd_ok_s = i_rden & ~empty_s & ~i_flush;
    end

    // Word written to memory and word read at the read pointer.
    always_comb begin
`ifdef SYN_FIFO_PARITY_EN
        wr_word_s    = {even_parity(i_wrdata), i_wrdata};
        rd_word_s    = mem_q[rd_ptr_q];
        rd_par_bad_s = rd_word_s[DATA_W] ^ even_parity(rd_word_s[DATA_W-1:0]);
`else
        wr_word_s    = i_wrdata;
        rd_word_s    = mem_q[rd_ptr_q];
        rd_par_bad_s = 1'b0;
`endif
    end

    // Next-state logic for pointers, occupancy, read port and sticky flags.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rddata_d    = rddata_q;
        rd_valid_d  = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        par_err_d   = 1'b0;

        if (i_flush) begin
            // Flush clears everything except the last read data, which holds.
            wr_ptr_d    = {ADDR_W{1'b0}};
            rd_ptr_d    = {ADDR_W{1'b0}};
            count_d     = {CNT_W{1'b0}};
            rddata_d    = rddata_q;
            rd_valid_d  = 1'b0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
            par_err_d   = 1'b0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (wr_ok_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE_C;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end

            if (rd_ok_s) begin
                rd_ptr_d   = rd_ptr_q + PTR_ONE_C;
                rddata_d   = rd_word_s[DATA_W-1:0];
                rd_valid_d = 1'b1;
                par_err_d  = rd_par_bad_s;
            end else begin
                rd_ptr_d   = rd_ptr_q;
                rddata_d   = rddata_q;
                rd_valid_d = 1'b0;
                par_err_d  = 1'b0;
            end

            case ({wr_ok_s, rd_ok_s})
                2'b10:   count_d = count_q + CNT_ONE_C;
                2'b01:   count_d = count_q - CNT_ONE_C;
                default: count_d = count_q;
            endcase

            // Sticky flags record the attempt, even when the other side of a
            // simultaneous request is still accepted.
            overflow_d  = overflow_q  | (i_wren & full_s);
            underflow_d = underflow_q | (i_rden & empty_s);
        end
    end

    // Control and read-port registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= {ADDR_W{1'b0}};
            rd_ptr_q    <= {ADDR_W{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            rddata_q    <= {DATA_W{1'b0}};
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            par_err_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rddata_q    <= rddata_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            par_err_q   <= par_err_d;
        end
    end

    // Storage array; not reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_q[wr_ptr_q] <= wr_word_s;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_full      = full_s;
    assign o_alm_full  = (count_q >= AFULL_LO_C) & ~full_s;
    assign o_empty     = empty_s;
    assign o_alm_empty = ~empty_s & (count_q <= AEMPTY_C);
    assign o_count     = count_q;
    assign o_rddata    = rddata_q;
    assign o_rd_valid  = rd_valid_q;
    assign o_overflow  = overflow_q;
    assign o_underflow = underflow_q;
    assign o_par_err   = par_err_q;

endmodule

// File: tb/tb_syn_fifo_ptr.sv
`timescale 1ns/1ps
module tb_syn_fifo_ptr;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int UPP_TH = 2;
    localparam int LOW_TH = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             i_flush = 1'b0;
    logic             i_wren = 1'b0;
    logic [7:0]       i_wrdata = 8'h00;
    logic             i_rden = 1'b0;
    logic             o_full, o_alm_full, o_rd_valid, o_empty, o_alm_empty;
    logic             o_overflow, o_underflow, o_par_err;
    logic [7:0]       o_rddata;
    logic [3:0]       o_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a queue of entries plus the observable registers.
    typedef struct {
        logic [7:0] data;
        logic       bad;
    } entry_t;
    entry_t     mq[$];
    logic       m_ovf = 1'b0, m_udf = 1'b0, m_valid = 1'b0, m_par = 1'b0;
    logic [7:0] m_rddata = 8'h00;

    typedef struct {
        logic       wren;
        logic [7:0] wdata;
        logic       rden;
        logic [3:0] e_count;
        logic       e_full, e_afull, e_empty, e_aempty, e_valid;
        logic [7:0] e_rddata;
    } vec_t;
    vec_t tbl[16];

    syn_fifo_ptr #(.DATA_W(DATA_W), .DEPTH(DEPTH), .UPP_TH(UPP_TH), .LOW_TH(LOW_TH)) dut (
        .clk(clk), .rst(rst), .i_flush(i_flush),
        .i_wren(i_wren), .i_wrdata(i_wrdata),
        .o_full(o_full), .o_alm_full(o_alm_full),
        .i_rden(i_rden), .o_rddata(o_rddata), .o_rd_valid(o_rd_valid),
        .o_empty(o_empty), .o_alm_empty(o_alm_empty), .o_count(o_count),
        .o_overflow(o_overflow), .o_underflow(o_underflow), .o_par_err(o_par_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 1'b0; m_udf = 1'b0; m_valid = 1'b0; m_par = 1'b0; m_rddata = 8'h00;
    endtask

    // One clock edge of the FIFO as the specification describes it.
    task automatic model_edge(input logic wren, input logic [7:0] wdata,
                              input logic rden, input logic flush);
        int     c;
        logic   was_full, was_empty;
        entry_t e;
        c = mq.size();
        was_full  = (c == DEPTH);
        was_empty = (c == 0);
        if (flush) begin
            mq.delete();
            m_ovf = 1'b0; m_udf = 1'b0; m_valid = 1'b0; m_par = 1'b0;
        end else begin
            if (wren && was_full)  m_ovf = 1'b1;
            if (rden && was_empty) m_udf = 1'b1;
            m_valid = 1'b0; m_par = 1'b0;
            if (rden && !was_empty) begin
                e = mq.pop_front();
                m_rddata = e.data; m_valid = 1'b1; m_par = e.bad;
            end
            if (wren && !was_full) begin
                e.data = wdata; e.bad = 1'b0;
                mq.push_back(e);
            end
        end
    endtask

    task automatic check_model();
        int c;
        c = mq.size();
        check("count",     32'(o_count),     32'(c));
        check("empty",     32'(o_empty),     32'(c == 0));
        check("full",      32'(o_full),      32'(c == DEPTH));
        check("alm_full",  32'(o_alm_full),  32'((c >= DEPTH - UPP_TH) && (c < DEPTH)));
        check("alm_empty", 32'(o_alm_empty), 32'((c > 0) && (c <= LOW_TH)));
        check("rd_valid",  32'(o_rd_valid),  32'(m_valid));
        check("rddata",    32'(o_rddata),    32'(m_rddata));
        check("overflow",  32'(o_overflow),  32'(m_ovf));
        check("underflow", 32'(o_underflow), 32'(m_udf));
        check("par_err",   32'(o_par_err),   32'(m_par));
    endtask

    task automatic check_reset_values();
        check("rst_count",     32'(o_count),     32'd0);
        check("rst_empty",     32'(o_empty),     32'd1);
        check("rst_full",      32'(o_full),      32'd0);
        check("rst_alm_full",  32'(o_alm_full),  32'd0);
        check("rst_alm_empty", 32'(o_alm_empty), 32'd0);
        check("rst_rd_valid",  32'(o_rd_valid),  32'd0);
        check("rst_rddata",    32'(o_rddata),    32'd0);
        check("rst_overflow",  32'(o_overflow),  32'd0);
        check("rst_underflow", 32'(o_underflow), 32'd0);
        check("rst_par_err",   32'(o_par_err),   32'd0);
    endtask

    // Drive inputs away from the edge, clock once, then compare against the model.
    task automatic step(input logic wren, input logic [7:0] wdata,
                        input logic rden, input logic flush);
        i_wren = wren; i_wrdata = wdata; i_rden = rden; i_flush = flush;
        @(posedge clk);
        model_edge(wren, wdata, rden, flush);
        #1;
        check_model();
    endtask

    initial begin
        int cnt;
        // Fill then drain vectors, with expectations taken from the fill/drain scenario.
        for (int i = 0; i < 8; i++) begin
            cnt = i + 1;
            tbl[i] = '{wren: 1'b1, wdata: 8'(8'h11 + i), rden: 1'b0, e_count: 4'(cnt),
                       e_full: (cnt == 8), e_afull: (cnt == 6 || cnt == 7), e_empty: 1'b0,
                       e_aempty: (cnt == 1 || cnt == 2), e_valid: 1'b0, e_rddata: 8'h00};
        end
        for (int i = 0; i < 8; i++) begin
            cnt = 7 - i;
            tbl[8+i] = '{wren: 1'b0, wdata: 8'h00, rden: 1'b1, e_count: 4'(cnt),
                         e_full: 1'b0, e_afull: (cnt == 6 || cnt == 7), e_empty: (cnt == 0),
                         e_aempty: (cnt == 1 || cnt == 2), e_valid: 1'b1, e_rddata: 8'(8'h11 + i)};
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_reset_values();
        rst = 1'b0;
        model_reset();

        // Table: fill and drain
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].wren, tbl[i].wdata, tbl[i].rden, 1'b0);
            check("tbl_count",     32'(o_count),     32'(tbl[i].e_count));
            check("tbl_full",      32'(o_full),      32'(tbl[i].e_full));
            check("tbl_alm_full",  32'(o_alm_full),  32'(tbl[i].e_afull));
            check("tbl_empty",     32'(o_empty),     32'(tbl[i].e_empty));
            check("tbl_alm_empty", 32'(o_alm_empty), 32'(tbl[i].e_aempty));
            check("tbl_rd_valid",  32'(o_rd_valid),  32'(tbl[i].e_valid));
            if (tbl[i].e_valid) check("tbl_rddata", 32'(o_rddata), 32'(tbl[i].e_rddata));
        end

        // Wrap across the pointer boundary
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            check("wrap_data", 32'(o_rddata), 32'(8'hA0 + i));
        end
        check("wrap_count0", 32'(o_count), 32'd0);

        // Simultaneous read/write at count 4
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h31 + i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'(8'h35 + i), 1'b1, 1'b0);
            check("simul_count", 32'(o_count), 32'd4);
            check("simul_data",  32'(o_rddata), 32'(8'h31 + i));
        end
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Empty with both requests
        step(1'b1, 8'h55, 1'b1, 1'b0);
        check("empty_both_count", 32'(o_count), 32'd1);
        check("empty_both_valid", 32'(o_rd_valid), 32'd0);
        check("empty_both_udf",   32'(o_underflow), 32'd1);

        // Flush clears occupancy and sticky flags
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("flush_count", 32'(o_count), 32'd0);
        check("flush_empty", 32'(o_empty), 32'd1);
        check("flush_udf",   32'(o_underflow), 32'd0);

        // Full with both requests, then overflow on a plain write
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b1, 1'b0);
        check("full_both_count", 32'(o_count), 32'd7);
        check("full_both_ovf",   32'(o_overflow), 32'd1);
        step(1'b1, 8'hC8, 1'b0, 1'b0);
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        check("ovf_count", 32'(o_count), 32'd8);
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        check("after_ovf_last", 32'(o_rddata), 32'h000000C8);

        // Flush with concurrent requests and set sticky flags
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'h77, 1'b0, 1'b0);
        step(1'b1, 8'h78, 1'b1, 1'b1);
        check("flush2_count", 32'(o_count), 32'd0);
        check("flush2_valid", 32'(o_rd_valid), 32'd0);

`ifdef SYN_FIFO_PARITY_EN
        // Corrupt the stored parity bit of entry 0, then pop it and a clean one
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        dut.mem_q[0][DATA_W] = ~dut.mem_q[0][DATA_W];
        mq[0].bad = 1'b1;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("par_bad",   32'(o_par_err), 32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("par_clean", 32'(o_par_err), 32'd0);
`endif

        // Randomized traffic, filling then draining bias
        for (int i = 0; i < 400; i++) begin
            logic w, r, f;
            if (i < 200) begin
                w = ($urandom_range(0, 99) < 70);
                r = ($urandom_range(0, 99) < 35);
            end else begin
                w = ($urandom_range(0, 99) < 35);
                r = ($urandom_range(0, 99) < 70);
            end
            f = ($urandom_range(0, 99) == 0);
            step(w, 8'($urandom), r, f);
        end

        // Asynchronous reset mid-burst, between edges
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h90 + i), 1'b0, 1'b0);
        step(1'b1, 8'h93, 1'b1, 1'b0);
        i_wren = 1'b1; i_rden = 1'b1; i_wrdata = 8'h94;
        #2;
        rst = 1'b1;
        #1;
        check_reset_values();
        i_wren = 1'b0; i_rden = 1'b0;
        #1;
        rst = 1'b0;
        model_reset();
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'hB1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("post_rst_data", 32'(o_rddata), 32'h000000B1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
